// File: rtl/user_io_pkg.sv
// Shared types for the user-IO Aurora link bring-up sequencer.
package user_io_pkg;

  localparam int unsigned LINK_RETRY_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPwr,
    StReset,
    StWaitLane,
    StWaitChan,
    StUp,
    StFail
  } link_state_e;

  // Transceiver is held in reset everywhere except while training or up.
  function automatic logic state_holds_rst(input link_state_e s);
    return !(s inside {StWaitLane, StWaitChan, StUp});
  endfunction

  function automatic logic [LINK_RETRY_W-1:0] retry_sat_inc(input logic [LINK_RETRY_W-1:0] c);
    return (c == '1) ? c : c + LINK_RETRY_W'(1);
  endfunction

endpackage

// File: rtl/user_io_link_fsm.sv
// One link's bring-up sequencer: status synchronisers, wait timer, FSM and retry counter.
module user_io_link_fsm
  import user_io_pkg::*;
#(
  parameter int unsigned RST_CYC     = 128,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MAX_RETRY   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    force_rst_i,
  input  logic                    gt_pwrgd_i,
  input  logic                    lane_up_i,
  input  logic                    chan_up_i,
  output logic                    link_rst_o,
  output logic                    link_up_o,
  output logic                    link_err_o,
  output logic [LINK_RETRY_W-1:0] retry_cnt_o
);

  localparam logic [CNT_W-1:0]        RstLoad     = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]        TimeoutLoad = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [LINK_RETRY_W-1:0] MaxRetry    = LINK_RETRY_W'(MAX_RETRY);

  // Bit 0 pwrgd, bit 1 lane_up, bit 2 chan_up.
  logic [2:0] sync1_q, sync2_q;
  logic       pwrgd, lane_up, chan_up;

  link_state_e              state_q, state_d;
  logic [CNT_W-1:0]         timer_q, timer_d;
  logic [LINK_RETRY_W-1:0]  retry_q, retry_d, retry_inc;
  logic                     retry_path;
  logic                     link_rst_q, link_up_q, link_err_q;

  assign pwrgd   = sync2_q[0];
  assign lane_up = sync2_q[1];
  assign chan_up = sync2_q[2];

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    retry_inc  = retry_sat_inc(retry_q);
    retry_path = 1'b0;
    if (!enable_i) begin
      state_d = StIdle;
    end else if (force_rst_i) begin
      state_d = StWaitPwr;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitPwr;
        StWaitPwr: begin
          if (pwrgd) begin
            state_d = StReset;
            timer_d = RstLoad;
          end
        end
        StReset: begin
          if (!pwrgd) begin
            state_d = StWaitPwr;
          end else if (timer_q == '0) begin
            state_d = StWaitLane;
            timer_d = TimeoutLoad;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        StWaitLane: begin
          if (!pwrgd) begin
            state_d = StWaitPwr;
          end else if (lane_up) begin
            state_d = StWaitChan;
            timer_d = TimeoutLoad;
          end else if (timer_q == '0) begin
            retry_path = 1'b1;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        StWaitChan: begin
          if (!pwrgd) begin
            state_d = StWaitPwr;
          end else if (chan_up) begin
            state_d = StUp;
            retry_d = '0;
          end else if (timer_q == '0 || !lane_up) begin
            retry_path = 1'b1;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        StUp: begin
          if (!chan_up || !pwrgd) retry_path = 1'b1;
        end
        StFail: state_d = StFail;
        default: state_d = StIdle;
      endcase
      // A failed attempt either retries from RESET or gives up for good.
      if (retry_path) begin
        retry_d = retry_inc;
        if (retry_inc >= MaxRetry) begin
          state_d = StFail;
        end else begin
          state_d = StReset;
          timer_d = RstLoad;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
      retry_q    <= '0;
      link_rst_q <= 1'b1;
      link_up_q  <= 1'b0;
      link_err_q <= 1'b0;
    end else begin
      sync1_q    <= {chan_up_i, lane_up_i, gt_pwrgd_i};
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      link_rst_q <= state_holds_rst(state_d);
      link_up_q  <= (state_d == StUp);
      link_err_q <= (state_d == StFail);
    end
  end

  assign link_rst_o  = link_rst_q;
  assign link_up_o   = link_up_q;
  assign link_err_o  = link_err_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: rtl/user_io_link_bringup_ctl.sv
// Aurora bring-up controller: one independent sequencer per link.
module user_io_link_bringup_ctl
  import user_io_pkg::*;
#(
  parameter int unsigned NUM_AUR_LINKS = 8,
  parameter int unsigned RST_CYC       = 128,
  parameter int unsigned TIMEOUT_CYC   = 1000000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned MAX_RETRY     = 8
) (
  input  logic                                  clk_per,
  input  logic                                  reset_per,
  input  logic [NUM_AUR_LINKS-1:0]              i_enable,
  input  logic [NUM_AUR_LINKS-1:0]              i_force_rst,
  input  logic [NUM_AUR_LINKS-1:0]              i_gt_pwrgd,
  input  logic [NUM_AUR_LINKS-1:0]              i_lane_up,
  input  logic [NUM_AUR_LINKS-1:0]              i_chan_up,
  output logic [NUM_AUR_LINKS-1:0]              o_link_rst,
  output logic [NUM_AUR_LINKS-1:0]              o_link_up,
  output logic [NUM_AUR_LINKS-1:0]              o_link_err,
  output logic [NUM_AUR_LINKS*LINK_RETRY_W-1:0] o_retry_cnt
);

  for (genvar g = 0; g < NUM_AUR_LINKS; g++) begin : g_link
    user_io_link_fsm #(
      .RST_CYC    (RST_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .CNT_W      (CNT_W),
      .MAX_RETRY  (MAX_RETRY)
    ) u_link_fsm (
      .clk_i      (clk_per),
      .rst_i      (reset_per),
      .enable_i   (i_enable[g]),
      .force_rst_i(i_force_rst[g]),
      .gt_pwrgd_i (i_gt_pwrgd[g]),
      .lane_up_i  (i_lane_up[g]),
      .chan_up_i  (i_chan_up[g]),
      .link_rst_o (o_link_rst[g]),
      .link_up_o  (o_link_up[g]),
      .link_err_o (o_link_err[g]),
      .retry_cnt_o(o_retry_cnt[g*LINK_RETRY_W +: LINK_RETRY_W])
    );
  end

endmodule

// File: tb/tb_user_io_link_bringup_ctl.sv
// Bench for the link bring-up controller: link 0 is sequenced, link 1 stays disabled.
module tb_user_io_link_bringup_ctl;
  import user_io_pkg::*;

  localparam int unsigned N = 2;

  logic                       clk = 1'b0;
  logic                       reset_per;
  logic [N-1:0]               en, frc, pg, ln, ch;
  logic [N-1:0]               link_rst, link_up, link_err;
  logic [N*LINK_RETRY_W-1:0]  retry;

  always #5 clk = ~clk;

  user_io_link_bringup_ctl #(
    .NUM_AUR_LINKS(N),
    .RST_CYC      (4),
    .TIMEOUT_CYC  (32),
    .CNT_W        (20),
    .MAX_RETRY    (3)
  ) dut (
    .clk_per    (clk),
    .reset_per  (reset_per),
    .i_enable   (en),
    .i_force_rst(frc),
    .i_gt_pwrgd (pg),
    .i_lane_up  (ln),
    .i_chan_up  (ch),
    .o_link_rst (link_rst),
    .o_link_up  (link_up),
    .o_link_err (link_err),
    .o_retry_cnt(retry)
  );

  typedef struct {
    logic        rst, en, frc, pg, ln, ch;
    int unsigned hold;
    logic        e_rst, e_up, e_err;
    int unsigned e_retry;
  } vec_t;

  typedef struct {
    int unsigned  cyc;
    logic [1:0]   rst, up, err;
    logic [15:0]  retry;
    int           step;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          step_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop every expectation that is due; one that is overdue is a failure too.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc || link_rst !== e.rst || link_up !== e.up || link_err !== e.err ||
          retry !== e.retry) begin
        bad++;
        $display("FAIL step%0d cyc=%0d/%0d: got rst=%b up=%b err=%b retry=%h, want rst=%b up=%b err=%b retry=%h",
                 e.step, cyc, e.cyc, link_rst, link_up, link_err, retry, e.rst, e.up, e.err,
                 e.retry);
      end
    end
  end

  function automatic vec_t mk(input logic r, input logic e, input logic f, input logic p,
                              input logic l, input logic c, input int unsigned h,
                              input logic er, input logic eu, input logic ee,
                              input int unsigned ert);
    vec_t v;
    v.rst = r; v.en = e; v.frc = f; v.pg = p; v.ln = l; v.ch = c; v.hold = h;
    v.e_rst = er; v.e_up = eu; v.e_err = ee; v.e_retry = ert;
    return v;
  endfunction

  // Drive link 0, queue the expectation for `hold` edges ahead, then let those edges pass.
  task automatic run_step(input vec_t v);
    exp_t e;
    reset_per = v.rst;
    en  = {1'b0, v.en};
    frc = {1'b0, v.frc};
    pg  = {1'b0, v.pg};
    ln  = {1'b0, v.ln};
    ch  = {1'b0, v.ch};
    e.cyc   = cyc + v.hold;
    e.rst   = {1'b1, v.e_rst};
    e.up    = {1'b0, v.e_up};
    e.err   = {1'b0, v.e_err};
    e.retry = {8'h00, 8'(v.e_retry)};
    e.step  = step_no;
    sb.push_back(e);
    step_no++;
    repeat (v.hold) @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset_per = 1'b1;
    en  = '0;
    frc = '0;
    pg  = '0;
    ln  = '0;
    ch  = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (link_rst !== '1 || link_up !== '0 || link_err !== '0 || retry !== '0) begin
      bad++;
      $display("FAIL reset state: rst=%b up=%b err=%b retry=%h", link_rst, link_up, link_err,
               retry);
    end

    // Bring-up: 2-cycle sync lag, 1 cycle WAIT_PWR, exactly 4 RESET cycles.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 1, 0, 0));
    // One-cycle chan_up glitch while UP.
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  3, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 1, 0, 0));
    // chan_up lost: WAIT_CHAN times out, then disable with retry_cnt=2 and re-enable.
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  3, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 32, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  5, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  5, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0,  1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  3, 0, 1, 0, 0));
    // force_rst from UP, lane_up never rises: three timeouts into FAIL.
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 31, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 35, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 20, 1, 0, 1, 3));
    // force_rst out of FAIL, then back up.
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1,  2, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_step(tbl[i]);

    // reset_per beats force_rst in the same cycle while UP.
    run_step(mk(1, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0));
    run_step(mk(1, 1, 0, 1, 1, 1,  1, 1, 0, 0, 0));
    // Power-good lost in WAIT_LANE: back to WAIT_PWR, no retry counted, no timeout there.
    run_step(mk(0, 1, 0, 1, 0, 0,  7, 0, 0, 0, 0));
    run_step(mk(0, 1, 0, 0, 0, 0,  2, 0, 0, 0, 0));
    run_step(mk(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    run_step(mk(0, 1, 0, 0, 0, 0, 40, 1, 0, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %0d expectation(s) never checked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
